// File: rtl/rr_entry_select.sv
// Round-robin entry buffer feeding the binary-tree Mux.
// Writes fill the lowest free slot; grants rotate from the last popped slot.
module rr_entry_select #(
  parameter int level   = 4,
  parameter int data_sz = 4,
  parameter int sel_sz  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [data_sz-1:0]            wr_data,
  output logic [(1<<(level-1))*data_sz-1:0] raw,
  output logic [sel_sz-1:0]             sel,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [level-1:0]              count
);

  localparam int N  = 1 << (level - 1);
  localparam int PW = (level > 1) ? level - 1 : 1;

  if (sel_sz < level - 1) begin : g_sel_chk
    $error("rr_entry_select: sel_sz must be >= level-1");
  end

  logic [data_sz-1:0] entry_q [N];
  logic [data_sz-1:0] entry_d [N];
  logic [N-1:0]       vld_q, vld_d;
  logic [PW-1:0]      ptr_q, ptr_d;

  logic [PW-1:0]      free_idx;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               wr_fire;
  logic               rd_fire;
  logic [level-1:0]   cnt;
  int                 scan;

  always_comb begin
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = PW'(i);
    end
  end

  // Scan starts one past the last granted slot and wraps.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = 0;
    for (int k = 1; k <= N; k++) begin
      scan = (int'(ptr_q) + k) % N;
      if (!gnt_any && vld_q[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(scan);
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + level'(vld_q[i]);
    end
  end

  assign wr_ready = ~&vld_q;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_valid = gnt_any;
  assign rd_fire  = gnt_any & rd_ready;
  assign sel      = sel_sz'(gnt_idx);
  assign count    = cnt;

  for (genvar g = 0; g < N; g++) begin : g_raw
    assign raw[g*data_sz +: data_sz] = entry_q[g];
  end

  // The free slot is never the granted slot, so both updates can coexist.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      entry_d[i] = entry_q[i];
    end
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (rd_fire) begin
      vld_d[gnt_idx] = 1'b0;
      ptr_d          = gnt_idx;
    end
    if (wr_fire) begin
      vld_d[free_idx]   = 1'b1;
      entry_d[free_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ptr_q <= PW'(N - 1);
      for (int i = 0; i < N; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      for (int i = 0; i < N; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule
